// File: rtl/seq_stim_pkg.sv
// Shared types and helpers for the seq_stim_driver stimulus/checker
// and for anything that needs the a/b -> y/z reference behaviour.
package seq_stim_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef struct packed {
    logic q1;
    logic q2;
  } gm_state_t;

  function automatic gm_state_t gm_next(
    input logic      a,
    input logic      b,
    input gm_state_t s
  );
    gm_state_t n;
    n.q1 = a | (b & ~s.q2);
    n.q2 = ~n.q1 & s.q1;
    return n;
  endfunction

  // x^8+x^6+x^5+x^4+1, new bit enters at bit 0
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/seq_stim_driver_model.sv
// seq_golden_model: posedge copy of the two-flop a/b -> y/z circuit.
// exp_y/exp_z are the outputs the real circuit shows after capturing a/b.
module seq_golden_model
  import seq_stim_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  output logic exp_y,
  output logic exp_z
);

  gm_state_t r_q;
  gm_state_t w_nxt;

  assign w_nxt = gm_next(a, b, r_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else begin
      r_q <= w_nxt;
    end
  end

  assign exp_y = w_nxt.q1;
  assign exp_z = ~w_nxt.q1 | (~w_nxt.q2 & b);

endmodule

// File: rtl/seq_stim_driver.sv
// LFSR stimulus driver and per-vector checker for the a/b -> y/z circuit.
// Define FIRST_FAIL_CAPTURE_EN to add the fail_seen/fail_idx ports.
module seq_stim_driver
  import seq_stim_pkg::*;
#(
  parameter int         NUM_VEC   = 16,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y_in,
  input  logic       z_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_cnt
`ifdef FIRST_FAIL_CAPTURE_EN
  ,
  output logic       fail_seen,
  output logic [7:0] fail_idx
`endif
);

  localparam logic [7:0] LAST_IDX = 8'(NUM_VEC - 1);

  state_t     r_state;
  logic [7:0] r_lfsr;
  logic [7:0] r_idx;
  logic [7:0] r_err;
  logic       r_a;
  logic       r_b;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic       w_exp_y;
  logic       w_exp_z;
  logic       w_mis;
`ifdef FIRST_FAIL_CAPTURE_EN
  logic       r_fail_seen;
  logic [7:0] r_fail_idx;
`endif

  seq_golden_model u_gm (
    .clk   (clk),
    .rst   (rst),
    .a     (r_a),
    .b     (r_b),
    .exp_y (w_exp_y),
    .exp_z (w_exp_z)
  );

  assign w_mis = (y_in != w_exp_y) || (z_in != w_exp_z);

  // r_idx names the vector currently on a/b; it is checked at the
  // next posedge while still held, then the following one launches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_lfsr  <= LFSR_SEED;
      r_idx   <= '0;
      r_err   <= '0;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
`ifdef FIRST_FAIL_CAPTURE_EN
      r_fail_seen <= 1'b0;
      r_fail_idx  <= '0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_RUN;
            r_a     <= LFSR_SEED[0];
            r_b     <= LFSR_SEED[1];
            r_lfsr  <= lfsr_next(LFSR_SEED);
            r_idx   <= '0;
            r_err   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
`ifdef FIRST_FAIL_CAPTURE_EN
            r_fail_seen <= 1'b0;
            r_fail_idx  <= '0;
`endif
          end
        end
        S_RUN: begin
          if (w_mis) begin
            if (r_err != 8'hFF) r_err <= r_err + 8'd1;
`ifdef FIRST_FAIL_CAPTURE_EN
            if (!r_fail_seen) begin
              r_fail_seen <= 1'b1;
              r_fail_idx  <= r_idx;
            end
`endif
          end
          if (r_idx == LAST_IDX) begin
            r_state <= S_FLUSH;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
          end else begin
            r_a    <= r_lfsr[0];
            r_b    <= r_lfsr[1];
            r_lfsr <= lfsr_next(r_lfsr);
            r_idx  <= r_idx + 8'd1;
          end
        end
        S_FLUSH: begin
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_pass  <= (r_err == 8'd0);
        end
      endcase
    end
  end

  assign a_out   = r_a;
  assign b_out   = r_b;
  assign busy    = r_busy;
  assign done    = r_done;
  assign pass    = r_pass;
  assign err_cnt = r_err;
`ifdef FIRST_FAIL_CAPTURE_EN
  assign fail_seen = r_fail_seen;
  assign fail_idx  = r_fail_idx;
`endif

endmodule

// File: tb/tb_seq_stim_driver.sv
// Bench for seq_stim_driver with a negedge a/b -> y/z circuit attached.
// Honours FIRST_FAIL_CAPTURE_EN when defined.
module tb_seq_stim_driver;

  localparam int NV  = 16;
  localparam int NV2 = 255;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic start  = 1'b0;
  logic start2 = 1'b0;
  int   mode   = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  logic       y_in, z_in, a_out, b_out, busy, done, pass;
  logic [7:0] err_cnt;
  logic       y2, z2, a2, b2, busy2, done2, pass2;
  logic [7:0] err2;
`ifdef FIRST_FAIL_CAPTURE_EN
  logic       fail_seen, fs2;
  logic [7:0] fail_idx, fi2;
`endif

  // circuit under test, one per driver; flops capture on negedge
  logic c_q1, c_q2, d_q1, d_q2;
  logic c_y, c_z, d_y, d_z;

  always @(negedge clk or posedge rst)
    if (rst) begin
      c_q1 <= 1'b0;
      c_q2 <= 1'b0;
    end else begin
      c_q1 <= a_out | (b_out & ~c_q2);
      c_q2 <= ~(a_out | (b_out & ~c_q2)) & c_q1;
    end

  always @(negedge clk or posedge rst)
    if (rst) begin
      d_q1 <= 1'b0;
      d_q2 <= 1'b0;
    end else begin
      d_q1 <= a2 | (b2 & ~d_q2);
      d_q2 <= ~(a2 | (b2 & ~d_q2)) & d_q1;
    end

  assign c_y  = c_q1;
  assign c_z  = ~c_q1 | (~c_q2 & b_out);
  assign d_y  = d_q1;
  assign d_z  = ~d_q1 | (~d_q2 & b2);
  assign y_in = (mode == 1) ? 1'b0 : (mode == 3) ? ~c_y : c_y;
  assign z_in = (mode >= 2) ? ~c_z : c_z;
  assign y2   = ~d_y;
  assign z2   = ~d_z;

  seq_stim_driver #(.NUM_VEC(NV), .LFSR_SEED(8'hA5)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .y_in(y_in), .z_in(z_in),
    .a_out(a_out), .b_out(b_out),
    .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt)
`ifdef FIRST_FAIL_CAPTURE_EN
    , .fail_seen(fail_seen), .fail_idx(fail_idx)
`endif
  );

  seq_stim_driver #(.NUM_VEC(NV2), .LFSR_SEED(8'hA5)) u_big (
    .clk(clk), .rst(rst), .start(start2),
    .y_in(y2), .z_in(z2),
    .a_out(a2), .b_out(b2),
    .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(err2)
`ifdef FIRST_FAIL_CAPTURE_EN
    , .fail_seen(fs2), .fail_idx(fi2)
`endif
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // run-level model: vectors, expected responses and mismatch list
  bit m_act = 1'b0;
  int m_t   = 0;
  bit va[NV], vb[NV], vy[NV], vz[NV], mis[NV];

  task automatic build_run();
    logic [7:0] l;
    bit q1, q2, n1, n2;
    l  = 8'hA5;
    q1 = 1'b0;
    q2 = 1'b0;
    for (int k = 0; k < NV; k++) begin
      va[k] = l[0];
      vb[k] = l[1];
      n1 = va[k] | (vb[k] & ~q2);
      n2 = ~n1 & q1;
      vy[k] = n1;
      vz[k] = ~n1 | (~n2 & vb[k]);
      q1 = n1;
      q2 = n2;
      mis[k] = (mode == 0) ? 1'b0 : (mode == 1) ? vy[k] : 1'b1;
      l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act = 1'b0;
    end else if (start && (!m_act || m_t > NV)) begin
      build_run();
      m_act = 1'b1;
      m_t   = 0;
    end else if (m_act && m_t < 1000) begin
      m_t = m_t + 1;
    end
  end

  function automatic int n_checked();
    if (!m_act) return 0;
    return (m_t < NV) ? m_t : NV;
  endfunction

  function automatic int exp_err();
    int n = 0;
    for (int i = 0; i < n_checked(); i++) n += int'(mis[i]);
    return (n > 255) ? 255 : n;
  endfunction

  function automatic int exp_fidx();
    for (int i = 0; i < n_checked(); i++) if (mis[i]) return i;
    return -1;
  endfunction

  int e_busy, e_done, e_a, e_b, e_err, e_fi;

  always @(negedge clk) begin
    e_busy = int'(m_act && m_t <= NV);
    e_done = int'(m_act && m_t > NV);
    e_a    = (m_act && m_t < NV) ? int'(va[m_t]) : 0;
    e_b    = (m_act && m_t < NV) ? int'(vb[m_t]) : 0;
    e_err  = exp_err();
    e_fi   = exp_fidx();
    chk("busy", int'(busy), e_busy);
    chk("done", int'(done), e_done);
    chk("a_out", int'(a_out), e_a);
    chk("b_out", int'(b_out), e_b);
    chk("err_cnt", int'(err_cnt), e_err);
    chk("pass", int'(pass), int'(e_done == 1 && e_err == 0));
`ifdef FIRST_FAIL_CAPTURE_EN
    chk("fail_seen", int'(fail_seen), int'(e_fi >= 0));
    chk("fail_idx", int'(fail_idx), (e_fi >= 0) ? e_fi : 0);
`endif
  end

  task automatic pulse_start(output int b0);
    @(negedge clk);
    #1 start = 1'b1;
    @(negedge clk);
    b0 = int'(busy);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int bound, inout int nb);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done) return;
      if (busy) nb++;
    end
    n_chk++;
    n_fail++;
    $display("FAIL done_timeout: done=%0b after %0d cycles, expected 1", done, bound);
  endtask

  initial begin
    int nb;
    int ny;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err_cnt), 0);
    chk("rst_a", int'(a_out), 0);
    #1 rst = 1'b0;

    // 1: clean run
    mode = 0;
    pulse_start(nb);
    wait_done(100, nb);
    chk("t1_busy_cycles", nb, NV + 1);
    chk("t1_pass", int'(pass), 1);
    chk("t1_err", int'(err_cnt), 0);
    chk("pin_a0", int'(va[0]), 1);
    chk("pin_b0", int'(vb[0]), 0);
    chk("pin_a1", int'(va[1]), 0);
    chk("pin_b1", int'(vb[1]), 1);
    chk("pin_a2", int'(va[2]), 1);
    chk("pin_y012", int'({vy[0], vy[1], vy[2]}), 7);
    chk("pin_z012", int'({vz[0], vz[1], vz[2]}), 2);

    // 2: y stuck at 0
    mode = 1;
    pulse_start(nb);
    wait_done(100, nb);
    ny = 0;
    for (int k = 0; k < NV; k++) ny += int'(vy[k]);
    chk("t2_err", int'(err_cnt), ny);
    chk("t2_err_nonzero", int'(err_cnt != 0), 1);
    chk("t2_pass", int'(pass), 0);

    // 3: z inverted
    mode = 2;
    pulse_start(nb);
    wait_done(100, nb);
    chk("t3_err", int'(err_cnt), 16);
    chk("t3_pass", int'(pass), 0);
`ifdef FIRST_FAIL_CAPTURE_EN
    chk("t3_fail_seen", int'(fail_seen), 1);
    chk("t3_fail_idx", int'(fail_idx), 0);
`endif

    // 4: start from DONE clears err; start mid-run ignored
    mode = 0;
    pulse_start(nb);
    chk("t4_err_clr", int'(err_cnt), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      nb += int'(busy);
    end
    #1 start = 1'b1;
    @(negedge clk);
    nb += int'(busy);
    #1 start = 1'b0;
    wait_done(100, nb);
    chk("t4_busy_cycles", nb, NV + 1);
    chk("t4_pass", int'(pass), 1);

    // 5: async reset at vector 7, then a clean run
    pulse_start(nb);
    repeat (7) @(negedge clk);
    chk("t5_busy_pre", int'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_busy", int'(busy), 0);
    chk("t5_done", int'(done), 0);
    chk("t5_pass", int'(pass), 0);
    chk("t5_err", int'(err_cnt), 0);
    chk("t5_ab", int'({a_out, b_out}), 0);
    @(negedge clk);
    #1 rst = 1'b0;
    pulse_start(nb);
    wait_done(100, nb);
    chk("t5_rerun_cycles", nb, NV + 1);
    chk("t5_rerun_pass", int'(pass), 1);
    chk("t5_rerun_err", int'(err_cnt), 0);

    // 6: 255 vectors, everything inverted
    @(negedge clk);
    #1 start2 = 1'b1;
    @(negedge clk);
    #1 start2 = 1'b0;
    for (int i = 0; i < 400 && !done2; i++) @(negedge clk);
    chk("t6_done", int'(done2), 1);
    chk("t6_err", int'(err2), 255);
    chk("t6_pass", int'(pass2), 0);
    chk("t6_busy", int'(busy2), 0);
`ifdef FIRST_FAIL_CAPTURE_EN
    chk("t6_fail_idx", int'(fi2), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
